// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared definitions for the instr_sequencer controller:
//                opcodes, controller states and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Opcodes carried in instruction bits [7:6]
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    // Controller phases; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_e;

    // Instruction field positions: op[7:6] rs[5:4] rt[3:2] rd[1:0]
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 2;
    localparam int RD_MSB  = 1;
    localparam int RD_LSB  = 0;
    localparam int JOFF_W  = 6;   // jump offset lives in bits [5:0]

endpackage
`default_nettype wire

// File: rtl/alu8.sv
`default_nettype none
// ============================================================================
//  Module      : alu8
//  Description : Combinational 8-bit add/subtract. The signed-overflow output
//                exists only when SEQ_OVF_FLAG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu8
    import seq_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sub_i,
`ifdef SEQ_OVF_FLAG_EN
    output logic       ovf_o,
`endif
    output logic [7:0] y_o
);

    logic [7:0] w_b_eff;

    // Subtraction is a + ~b + 1; the carry-in is the sub select itself
    always_comb begin
        w_b_eff = sub_i ? ~b_i : b_i;
        y_o     = a_i + w_b_eff + {7'd0, sub_i};
`ifdef SEQ_OVF_FLAG_EN
        // Same-sign operands producing an opposite-sign result overflowed
        ovf_o   = (a_i[7] == w_b_eff[7]) && (y_o[7] != a_i[7]);
`endif
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch/decode/execute/write-back controller for the 8-bit
//                microprocessor. Owns the PC and drives the 4x8 register
//                file. Optional sticky overflow flag: SEQ_OVF_FLAG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Run,
    output logic              InstrReq,
    output logic [PC_W-1:0]   InstrAddr,
    input  logic [7:0]        Instr,
    input  logic              InstrValid,
    output logic [1:0]        Read1,
    output logic [1:0]        Read2,
    input  logic [DATA_W-1:0] ReadD1,
    input  logic [DATA_W-1:0] ReadD2,
    output logic              RegWrite,
    output logic [1:0]        WriteR,
    output logic [DATA_W-1:0] WriteD,
`ifdef SEQ_OVF_FLAG_EN
    output logic              Ovf,
`endif
    output logic              InstrDone
);

    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        read1_q, read1_d, read2_q, read2_d;
    logic              regwrite_q, regwrite_d;
    logic [1:0]        writer_q, writer_d;
    logic [DATA_W-1:0] writed_q, writed_d;
    logic              done_q, done_d;
`ifdef SEQ_OVF_FLAG_EN
    logic              ovf_q, ovf_d;
    logic              alu_ovf;
`endif

    logic [1:0]        op;
    logic [7:0]        alu_b;
    logic [7:0]        alu_y;
    logic [PC_W-1:0]   jmp_target;

    assign op = ir_q[OP_MSB:OP_LSB];

    // ADDI replaces operand B with the sign-extended 2-bit immediate
    assign alu_b = (op == OP_ADDI) ? {{6{ir_q[RD_MSB]}}, ir_q[RD_MSB:RD_LSB]} : b_q;

    // Jump target is relative to the instruction following the JMP
    assign jmp_target = pc_q + PC_W'(1)
                      + {{(PC_W-JOFF_W){ir_q[JOFF_W-1]}}, ir_q[JOFF_W-1:0]};

    alu8 u_alu (
        .a_i   (a_q),
        .b_i   (alu_b),
        .sub_i (op == OP_SUB),
`ifdef SEQ_OVF_FLAG_EN
        .ovf_o (alu_ovf),
`endif
        .y_o   (alu_y)
    );

    // Request is decoded from state; gated by reset so it is low during reset
    assign InstrReq  = reset_n && Run && (state_q == ST_FETCH);
    assign InstrAddr = pc_q;
    assign Read1     = read1_q;
    assign Read2     = read2_q;
    assign RegWrite  = regwrite_q;
    assign WriteR    = writer_q;
    assign WriteD    = writed_q;
    assign InstrDone = done_q;
`ifdef SEQ_OVF_FLAG_EN
    assign Ovf       = ovf_q;
`endif

    // Next-state logic for the four-phase instruction cycle
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        read1_d    = read1_q;
        read2_d    = read2_q;
        regwrite_d = 1'b0;
        writer_d   = writer_q;
        writed_d   = writed_q;
        done_d     = 1'b0;
`ifdef SEQ_OVF_FLAG_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            ST_FETCH: begin
                // Memory acknowledge counts only while the request is up
                if (Run && InstrValid) begin
                    ir_d    = Instr;
                    read1_d = Instr[RS_MSB:RS_LSB];
                    read2_d = Instr[RT_MSB:RT_LSB];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = ReadD1;
                b_d     = ReadD2;
                state_d = ST_EXEC;
                // JMP retires in EXEC, so its done pulse is armed here
                done_d  = (op == OP_JMP);
            end
            ST_EXEC: begin
                if (op == OP_JMP) begin
                    pc_d    = jmp_target;
                    state_d = ST_FETCH;
                end else begin
                    writed_d   = alu_y;
                    writer_d   = (op == OP_ADDI) ? ir_q[RT_MSB:RT_LSB] : ir_q[RD_MSB:RD_LSB];
                    regwrite_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_WB;
`ifdef SEQ_OVF_FLAG_EN
                    ovf_d      = ovf_q | alu_ovf;
`endif
                end
            end
            ST_WB: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State and output registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            read1_q    <= '0;
            read2_q    <= '0;
            regwrite_q <= 1'b0;
            writer_q   <= '0;
            writed_q   <= '0;
            done_q     <= 1'b0;
`ifdef SEQ_OVF_FLAG_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            read1_q    <= read1_d;
            read2_q    <= read2_d;
            regwrite_q <= regwrite_d;
            writer_q   <= writer_d;
            writed_q   <= writed_d;
            done_q     <= done_d;
`ifdef SEQ_OVF_FLAG_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer. The bench plays the
//                instruction memory and the register file, and predicts each
//                instruction's effect with integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, Run, InstrReq, InstrValid, RegWrite, InstrDone;
    logic [7:0] InstrAddr, Instr, ReadD1, ReadD2, WriteD;
    logic [1:0] Read1, Read2, WriteR;
`ifdef SEQ_OVF_FLAG_EN
    logic       Ovf;
`endif

    logic [7:0] rf [4];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_pc  = 0;
    int         m_reg [4];
    int         m_ovf = 0;

    always #5 clk = ~clk;

    assign ReadD1 = rf[Read1];
    assign ReadD2 = rf[Read2];

    instr_sequencer #(.PC_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Run        (Run),
        .InstrReq   (InstrReq),
        .InstrAddr  (InstrAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Read1      (Read1),
        .Read2      (Read2),
        .ReadD1     (ReadD1),
        .ReadD2     (ReadD2),
        .RegWrite   (RegWrite),
        .WriteR     (WriteR),
        .WriteD     (WriteD),
`ifdef SEQ_OVF_FLAG_EN
        .Ovf        (Ovf),
`endif
        .InstrDone  (InstrDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; the bench register file takes the write the DUT requests
    task automatic tick();
        if (RegWrite === 1'b1) rf[WriteR] = WriteD;
        @(negedge clk);
    endtask

    task automatic set_reg(input int idx, input int val);
        rf[idx]    = 8'(val);
        m_reg[idx] = val;
    endtask

    function automatic int wrap8(input int v);
        return ((v % 256) + 256) % 256;
    endfunction

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Run one instruction through the DUT and compare it with the prediction
    task automatic exec_one(input logic [7:0] ins, input int waits, input int gaps, input bit abort_wb);
        int op, rs, rt, rd, imm, off, sres, res, exp_r, new_pc, k, nwe;
        bit ovf_now, done, aborted;
        op  = int'(ins[7:6]);
        rs  = int'(ins[5:4]);
        rt  = int'(ins[3:2]);
        rd  = int'(ins[1:0]);
        imm = int'(ins[1:0]);
        if (imm >= 2) imm -= 4;
        off = int'(ins[5:0]);
        if (off >= 32) off -= 64;
        case (op)
            0:       sres = to_signed8(m_reg[rs]) + to_signed8(m_reg[rt]);
            1:       sres = to_signed8(m_reg[rs]) + imm;
            2:       sres = to_signed8(m_reg[rs]) - to_signed8(m_reg[rt]);
            default: sres = 0;
        endcase
        res     = wrap8(sres);
        ovf_now = (op != 3) && (sres > 127 || sres < -128);
        exp_r   = (op == 1) ? rt : rd;
        new_pc  = (op == 3) ? wrap8(m_pc + 1 + off) : wrap8(m_pc + 1);

        for (int g = 0; g < gaps; g++) begin
            Run = 1'b0; InstrValid = 1'($urandom_range(0, 1)); Instr = 8'($urandom);
            #1;
            check("idle_req", InstrReq, 0);
            check("idle_pc", InstrAddr, m_pc);
            tick();
        end
        for (int w = 0; w < waits; w++) begin
            Run = 1'b1; InstrValid = 1'b0; Instr = 8'($urandom);
            #1;
            check("wait_req", InstrReq, 1);
            check("wait_pc", InstrAddr, m_pc);
            tick();
        end
        Run = 1'b1; InstrValid = 1'b1; Instr = ins;
        #1;
        check("fetch_req", InstrReq, 1);
        check("fetch_addr", InstrAddr, m_pc);
        tick();

        k = 2; done = 0; nwe = 0; aborted = 0;
        while (!done && k <= 8) begin
            Run = 1'($urandom_range(0, 1)); InstrValid = 1'($urandom_range(0, 1)); Instr = 8'($urandom);
            #1;
            check("busy_req", InstrReq, 0);
            check("read1", Read1, rs);
            check("read2", Read2, rt);
            if (RegWrite === 1'b1) begin
                nwe++;
                check("write_r", WriteR, exp_r);
                check("write_d", WriteD, res);
`ifdef SEQ_OVF_FLAG_EN
                check("ovf", Ovf, m_ovf | int'(ovf_now));
`endif
            end
            if (InstrDone === 1'b1) begin
                done = 1;
                check("latency", k, (op == 3) ? 3 : 4);
                if (abort_wb && op != 3) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_regwrite", RegWrite, 0);
                    check("rst_done", InstrDone, 0);
                    check("rst_pc", InstrAddr, 0);
                    check("rst_req", InstrReq, 0);
                    check("rst_wd", WriteD, 0);
                    check("rst_wr", WriteR, 0);
                    check("rst_read1", Read1, 0);
`ifdef SEQ_OVF_FLAG_EN
                    check("rst_ovf", Ovf, 0);
`endif
                    tick();
                    check("rst_no_write", rf[exp_r], m_reg[exp_r]);
                    reset_n = 1'b1;
                    m_pc    = 0;
                    m_ovf   = 0;
                    aborted = 1;
                end
            end
            if (!aborted) tick();
            k++;
        end
        if (aborted) return;
        check("retired", done, 1);
        check("we_count", nwe, (op == 3) ? 0 : 1);
        if (op != 3) begin
            m_reg[exp_r] = res;
            m_ovf        = m_ovf | int'(ovf_now);
            check("rf_value", rf[exp_r], m_reg[exp_r]);
        end
        m_pc = new_pc;
    endtask

    initial begin
        logic [5:0] off6;
        for (int i = 0; i < 4; i++) begin
            rf[i] = 8'h00; m_reg[i] = 0;
        end
        reset_n = 1'b0; Run = 1'b1; InstrValid = 1'b0; Instr = 8'h00;
        @(negedge clk); @(negedge clk);
        #1;
        check("reset_req", InstrReq, 0);
        check("reset_pc", InstrAddr, 0);
        check("reset_regwrite", RegWrite, 0);
        check("reset_done", InstrDone, 0);
        check("reset_wd", WriteD, 0);
        check("reset_rd", {Read1, Read2, WriteR}, 0);
`ifdef SEQ_OVF_FLAG_EN
        check("reset_ovf", Ovf, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // ADDI r1 = r0 + 1 straight out of reset
        exec_one(8'h45, 0, 0, 0);
        // ADD r3 = r1 + r2 with signed overflow
        set_reg(1, 8'h7F); set_reg(2, 8'h01);
        exec_one(8'h1B, 1, 0, 0);
        // SUB r3 = r1 - r2 wraps to 0xFF
        set_reg(1, 8'h00); set_reg(2, 8'h01);
        exec_one(8'h9B, 0, 1, 0);
        // Jump to PC 5, then JMP -2 from there to PC 4
        off6 = 6'(5 - (m_pc + 1));
        exec_one({2'b11, off6}, 0, 0, 0);
        exec_one(8'hFE, 0, 0, 0);
        // Wait states and Run low
        exec_one(8'h27, 3, 2, 0);
        // Self-loop jump keeps the PC
        exec_one(8'hFF, 0, 0, 0);
        exec_one(8'hFF, 1, 1, 0);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0)
                set_reg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            exec_one(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0, 0);
        end

        // Reset asserted in WB, then resume from PC 0
        set_reg(1, 8'h7F); set_reg(2, 8'h01);
        exec_one(8'h1B, 0, 0, 1);
        exec_one(8'h45, 0, 0, 0);
        exec_one(8'h9B, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
